chess_board_renderer: RTL and testbench
=======================================

CHESS_BOARD_RENDERER -- requirements
Module: chess_board_renderer

Interface
REQ-001 SHALL have parameter BOARD_N, default 3: squares per board side, range 2..8.
REQ-002 SHALL have parameter SQ_SIZE, default 100: square edge in pixels; must be a multiple of ART_N.
REQ-003 SHALL have parameter ORIGIN_X, default 200: left board pixel column.
REQ-004 SHALL have parameter ORIGIN_Y, default 200: top board pixel row.
REQ-005 SHALL have parameter ART_N, default 10: sprite edge in art pixels.
REQ-006 SHALL have parameter BLINK_FRAMES, default 30: frames per cursor blink half-period.
REQ-007 SHALL have port clock, input, 1 bit: single pixel clock.
REQ-008 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port hcount, input, 11 bits: pixel column from the vga module.
REQ-010 SHALL have port vcount, input, 10 bits: pixel row from the vga module.
REQ-011 SHALL have port wr_en, input, 1 bit: board-memory write strobe.
REQ-012 SHALL have port wr_addr, input, 6 bits: square index, row*BOARD_N+col.
REQ-013 SHALL have port wr_piece, input, 4 bits: bit3 = colour (1 black); bits2:0 = type (0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king, 7 reserved/empty).
REQ-014 SHALL have port cursor, input, 6 bits: highlighted square index.
REQ-015 SHALL have ports R, G, B, output, 10 bits each: registered pixel colour.

Function
REQ-016 SHALL hold BOARD_N*BOARD_N 4-bit piece registers; wr_en with wr_addr < BOARD_N^2 writes on the rising clock edge; wr_addr out of range is ignored.
REQ-017 SHALL use a 3-stage pipeline: S1 registers col, row, x_off, y_off and in_board; S2 registers square index, piece code, art_x = x_off/(SQ_SIZE/ART_N) and art_y; S3 registers R/G/B. Latency is exactly 3 clocks from hcount/vcount to output.
REQ-018 SHALL treat squares as half-open: col k covers [ORIGIN_X+k*SQ_SIZE, ORIGIN_X+(k+1)*SQ_SIZE); rows likewise. Edge pixels belong to exactly one square.
REQ-019 SHALL output 8'b000_000_00 outside the board; light square 8'b111_110_10 when (row+col) is even; dark square 8'b101_000_00 otherwise.
REQ-020 SHALL map the 8-bit colour to R[9:7], G[9:7], B[9:8], with all other bits 0.
REQ-021 SHALL overlay sprite pixels on the square colour: 8'b111_111_11 for white pieces, 8'b001_001_01 for black pieces; type 0 or 7 draws no sprite.
REQ-022 SHALL index sprites with art row 0 as the top of the square (no vertical flip), art column 0 as the left.
REQ-023 SHALL draw the cursor as a 4-pixel-wide border inside the square cursor, colour 8'b000_111_00, taking priority over the sprite; cursor >= BOARD_N^2 draws nothing.
REQ-024 SHALL make a write to square s visible from the first pixel of s entering S2 after the write edge; a write concurrent with S2 reading s returns the new value.
REQ-025 SHALL count frames at hcount==0 && vcount==0; the blink counter wraps at BLINK_FRAMES-1 and toggles blink_on at each wrap.

Reset
REQ-026 SHALL, while reset_n is low, force R=G=B=0, clear all piece registers to 0, clear pipeline valid flags, the frame counter and blink_on=1; outputs reflect live input 3 clocks after reset_n rises.
REQ-027 SHALL abort the pipeline on reset mid-line; no stale pixel is emitted after release.

Configuration
REQ-028 With CURSOR_BLINK_EN defined, SHALL draw the cursor border only while blink_on=1.
REQ-029 Without CURSOR_BLINK_EN, SHALL draw the cursor border steadily, with the frame counter and blink_on removed from the design.

Structure
REQ-030 SHALL take the colour constants, the piece-type codes and the PIECE_W=4 width from the shared package chess_pkg.
REQ-031 SHALL place sprite bitmaps in a sub-module piece_sprite_rom (inputs type, art_x, art_y; output 1-bit pixel; combinational; registered by the parent in S3).

Verification
REQ-032 Scenario: reset, defaults; hcount=250, vcount=250 -> after 3 clocks R[9:7]=111, G[9:7]=110, B[9:8]=10.
REQ-033 Scenario: write wr_addr=4, wr_piece=4'b0101; pixel (355,355) (art 5,5, queen body) -> white 111/111/11 at cycle +3.
REQ-034 Scenario: wr_piece=4'b1101 at addr 4; same pixel -> 001/001/01; pixel (301,301) (art 0,0, blank) -> light square colour.
REQ-035 Scenario: hcount=300, vcount=250 -> dark square (col 1); hcount=500 -> outside, all zero.
REQ-036 Scenario: cursor=0, pixel (201,250) -> 000/111/00; with CURSOR_BLINK_EN, after 30 frame starts -> light square colour.
REQ-037 Scenario: assert reset_n low mid-line after writes -> R=G=B=0 immediately; after release, pixel (355,355) -> light square colour (board cleared).

Source files
------------

// File: rtl/chess_pkg.sv
// Shared constants for the chess board renderer: piece encoding, 8-bit palette
// and the 8-bit to 30-bit RGB expansion used at the output stage.
package chess_pkg;

  localparam int PIECE_W = 4;
  localparam int ART_W   = 4;

  typedef enum logic [2:0] {
    PT_EMPTY  = 3'd0,
    PT_PAWN   = 3'd1,
    PT_KNIGHT = 3'd2,
    PT_BISHOP = 3'd3,
    PT_ROOK   = 3'd4,
    PT_QUEEN  = 3'd5,
    PT_KING   = 3'd6,
    PT_RSVD   = 3'd7
  } piece_type_e;

  localparam logic [7:0] COL_OFF      = 8'b000_000_00;
  localparam logic [7:0] COL_LIGHT    = 8'b111_110_10;
  localparam logic [7:0] COL_DARK     = 8'b101_000_00;
  localparam logic [7:0] COL_WHITE_PC = 8'b111_111_11;
  localparam logic [7:0] COL_BLACK_PC = 8'b001_001_01;
  localparam logic [7:0] COL_CURSOR   = 8'b000_111_00;

  // RRR_GGG_BB lands on the top bits of each 10-bit channel
  function automatic logic [29:0] expand_rgb(input logic [7:0] c);
    return {c[7:5], 7'b0, c[4:2], 7'b0, c[1:0], 8'b0};
  endfunction

endpackage

// File: rtl/piece_sprite_rom.sv
// 10x10 one-bit piece bitmaps; art row 0 is the top of the square, art column 0
// the left. Empty, reserved and out-of-range coordinates read as 0.
module piece_sprite_rom
  import chess_pkg::*;
(
  input  piece_type_e      i_type,
  input  logic [ART_W-1:0] i_art_x,
  input  logic [ART_W-1:0] i_art_y,
  output logic             o_pixel
);

  localparam int ART = 10;
  typedef logic [0:ART-1] art_row_t;

  localparam art_row_t PAWN [ART] = '{
    10'b0000000000, 10'b0000000000, 10'b0000110000, 10'b0001111000, 10'b0001111000,
    10'b0000110000, 10'b0001111000, 10'b0011111100, 10'b0011111100, 10'b0000000000};
  localparam art_row_t KNIGHT [ART] = '{
    10'b0000000000, 10'b0001100000, 10'b0011111000, 10'b0111111100, 10'b0110111100,
    10'b0000111100, 10'b0001111000, 10'b0011111000, 10'b0111111110, 10'b0000000000};
  localparam art_row_t BISHOP [ART] = '{
    10'b0000000000, 10'b0000110000, 10'b0001101000, 10'b0011011100, 10'b0011111100,
    10'b0001111000, 10'b0000110000, 10'b0001111000, 10'b0111111110, 10'b0000000000};
  localparam art_row_t ROOK [ART] = '{
    10'b0000000000, 10'b0110110110, 10'b0111111110, 10'b0011111100, 10'b0011111100,
    10'b0011111100, 10'b0011111100, 10'b0111111110, 10'b0111111110, 10'b0000000000};
  localparam art_row_t QUEEN [ART] = '{
    10'b0000000000, 10'b0100110010, 10'b0110110110, 10'b0111111110, 10'b0011111100,
    10'b0011111100, 10'b0001111000, 10'b0011111100, 10'b0111111110, 10'b0000000000};
  localparam art_row_t KING [ART] = '{
    10'b0000110000, 10'b0001111000, 10'b0000110000, 10'b0011111100, 10'b0111111110,
    10'b0111111110, 10'b0011111100, 10'b0001111000, 10'b0111111110, 10'b0000000000};

  art_row_t w_row;

  always_comb begin
    w_row = '0;
    if (i_art_y < ART_W'(ART)) begin
      case (i_type)
        PT_PAWN:   w_row = PAWN[i_art_y];
        PT_KNIGHT: w_row = KNIGHT[i_art_y];
        PT_BISHOP: w_row = BISHOP[i_art_y];
        PT_ROOK:   w_row = ROOK[i_art_y];
        PT_QUEEN:  w_row = QUEEN[i_art_y];
        PT_KING:   w_row = KING[i_art_y];
        default:   w_row = '0;
      endcase
    end
  end

  assign o_pixel = (i_art_x < ART_W'(ART)) ? w_row[i_art_x] : 1'b0;

endmodule

// File: rtl/chess_board_renderer.sv
// Three-stage VGA overlay drawing a BOARD_N x BOARD_N chess board with sprites and
// a cursor border. Define CURSOR_BLINK_EN to make the cursor blink every BLINK_FRAMES.
module chess_board_renderer
  import chess_pkg::*;
#(
  parameter int BOARD_N      = 3,
  parameter int SQ_SIZE      = 100,
  parameter int ORIGIN_X     = 200,
  parameter int ORIGIN_Y     = 200,
  parameter int ART_N        = 10,
  parameter int BLINK_FRAMES = 30
)(
  input  logic               clock,
  input  logic               reset_n,
  input  logic [10:0]        hcount,
  input  logic [9:0]         vcount,
  input  logic               wr_en,
  input  logic [5:0]         wr_addr,
  input  logic [PIECE_W-1:0] wr_piece,
  input  logic [5:0]         cursor,
  output logic [9:0]         R,
  output logic [9:0]         G,
  output logic [9:0]         B
);

  localparam int NSQ    = BOARD_N * BOARD_N;
  localparam int IDX_W  = $clog2(NSQ);
  localparam int OFF_W  = $clog2(SQ_SIZE);
  localparam int BORDER = 4;

  localparam logic [10:0]      X_LO    = 11'(ORIGIN_X);
  localparam logic [10:0]      X_HI    = 11'(ORIGIN_X + BOARD_N * SQ_SIZE);
  localparam logic [10:0]      SQ_X    = 11'(SQ_SIZE);
  localparam logic [9:0]       Y_LO    = 10'(ORIGIN_Y);
  localparam logic [9:0]       Y_HI    = 10'(ORIGIN_Y + BOARD_N * SQ_SIZE);
  localparam logic [9:0]       SQ_Y    = 10'(SQ_SIZE);
  localparam logic [OFF_W-1:0] ART_DIV = OFF_W'(SQ_SIZE / ART_N);
  localparam logic [OFF_W-1:0] BRD_LO  = OFF_W'(BORDER);
  localparam logic [OFF_W-1:0] BRD_HI  = OFF_W'(SQ_SIZE - BORDER);
  localparam logic [6:0]       NSQ7    = 7'(NSQ);
  localparam logic [5:0]       N6      = 6'(BOARD_N);

  logic [PIECE_W-1:0] r_board [NSQ];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NSQ; i++) r_board[i] <= '0;
    end else if (wr_en && ({1'b0, wr_addr} < NSQ7)) begin
      r_board[wr_addr[IDX_W-1:0]] <= wr_piece;
    end
  end

  logic w_cursor_vis;
`ifdef CURSOR_BLINK_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_blink_on;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if ((hcount == 11'd0) && (vcount == 10'd0)) begin
      if (r_frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        r_frame_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end
  assign w_cursor_vis = r_blink_on;
`else
  assign w_cursor_vis = 1'b1;
`endif

  // ---- S1: board-relative square and offset within the square
  logic [10:0] w_dx;
  logic [9:0]  w_dy;
  logic        w_inb;
  assign w_dx  = hcount - X_LO;
  assign w_dy  = vcount - Y_LO;
  assign w_inb = (hcount >= X_LO) && (hcount < X_HI) && (vcount >= Y_LO) && (vcount < Y_HI);

  logic [2:0]       r_col_p1, r_row_p1;
  logic [OFF_W-1:0] r_xoff_p1, r_yoff_p1;
  logic             r_inb_p1, r_vld_p1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_vld_p1 <= 1'b0;
    else          r_vld_p1 <= 1'b1;
  end

  always_ff @(posedge clock) begin
    r_col_p1  <= 3'(w_dx / SQ_X);
    r_row_p1  <= 3'(w_dy / SQ_Y);
    r_xoff_p1 <= OFF_W'(w_dx % SQ_X);
    r_yoff_p1 <= OFF_W'(w_dy % SQ_Y);
    r_inb_p1  <= w_inb;
  end

  // ---- S2: square index, piece lookup, art coordinates, border flag
  logic [5:0]         w_idx;
  logic [PIECE_W-1:0] w_piece;
  logic               w_border;
  assign w_idx    = {3'b0, r_row_p1} * N6 + {3'b0, r_col_p1};
  assign w_border = (r_xoff_p1 < BRD_LO) || (r_xoff_p1 >= BRD_HI) ||
                    (r_yoff_p1 < BRD_LO) || (r_yoff_p1 >= BRD_HI);

  always_comb begin
    w_piece = '0;
    if (r_inb_p1 && ({1'b0, w_idx} < NSQ7)) begin
      if (wr_en && (wr_addr == w_idx)) w_piece = wr_piece;  // write landing on this edge wins
      else                             w_piece = r_board[w_idx[IDX_W-1:0]];
    end
  end

  logic [5:0]         r_idx_p2;
  logic [PIECE_W-1:0] r_piece_p2;
  logic [ART_W-1:0]   r_artx_p2, r_arty_p2;
  logic               r_border_p2, r_light_p2, r_inb_p2, r_vld_p2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_vld_p2 <= 1'b0;
    else          r_vld_p2 <= r_vld_p1;
  end

  always_ff @(posedge clock) begin
    r_idx_p2    <= w_idx;
    r_piece_p2  <= w_piece;
    r_artx_p2   <= ART_W'(r_xoff_p1 / ART_DIV);
    r_arty_p2   <= ART_W'(r_yoff_p1 / ART_DIV);
    r_border_p2 <= w_border;
    r_light_p2  <= ~(r_row_p1[0] ^ r_col_p1[0]);
    r_inb_p2    <= r_inb_p1;
  end

  // ---- S3: layer square, sprite and cursor, then register the pixel
  logic       w_sprite;
  logic [7:0] w_col8;

  piece_sprite_rom u_rom (
    .i_type  (piece_type_e'(r_piece_p2[2:0])),
    .i_art_x (r_artx_p2),
    .i_art_y (r_arty_p2),
    .o_pixel (w_sprite)
  );

  always_comb begin
    w_col8 = COL_OFF;
    if (r_inb_p2) begin
      w_col8 = r_light_p2 ? COL_LIGHT : COL_DARK;
      if (w_sprite) w_col8 = r_piece_p2[3] ? COL_BLACK_PC : COL_WHITE_PC;
      if (w_cursor_vis && r_border_p2 && (r_idx_p2 == cursor) && ({1'b0, cursor} < NSQ7))
        w_col8 = COL_CURSOR;
    end
  end

  logic [29:0] r_rgb_p3;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_rgb_p3 <= '0;
    else          r_rgb_p3 <= r_vld_p2 ? expand_rgb(w_col8) : 30'd0;
  end

  assign {R, G, B} = r_rgb_p3;

endmodule

// File: tb/tb_chess_board_renderer.sv
// Directed bench for chess_board_renderer; expected pixels queue up when a pixel
// is driven and are compared three clocks later.
module tb_chess_board_renderer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [10:0] hcount = 11'd1000;
  logic [9:0]  vcount = 10'd1000;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = 6'd0;
  logic [3:0]  wr_piece = 4'd0;
  logic [5:0]  cursor = 6'd63;
  logic [9:0]  R, G, B;

  chess_board_renderer dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .hcount   (hcount),
    .vcount   (vcount),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_piece (wr_piece),
    .cursor   (cursor),
    .R        (R),
    .G        (G),
    .B        (B)
  );

  always #5 clock = ~clock;

  localparam logic [7:0] C_OFF   = 8'b000_000_00;
  localparam logic [7:0] C_LIGHT = 8'b111_110_10;
  localparam logic [7:0] C_DARK  = 8'b101_000_00;
  localparam logic [7:0] C_WPC   = 8'b111_111_11;
  localparam logic [7:0] C_BPC   = 8'b001_001_01;
  localparam logic [7:0] C_CUR   = 8'b000_111_00;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int          q_due [$];
  logic [29:0] q_exp [$];
  string       q_tag [$];

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [29:0] rgb(input logic [7:0] c);
    return {c[7:5], 7'd0, c[4:2], 7'd0, c[1:0], 8'd0};
  endfunction

  task automatic check(input string tag, input logic [29:0] obs, input logic [29:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed RGB=%h expected RGB=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      check(q_tag[0], {R, G, B}, q_exp[0]);
      void'(q_due.pop_front());
      void'(q_exp.pop_front());
      void'(q_tag.pop_front());
    end
  end

  task automatic px(input int h, input int v, input logic [7:0] c, input string tag);
    @(negedge clock);
    hcount = 11'(h);
    vcount = 10'(v);
    q_due.push_back(cyc + 3);
    q_exp.push_back(rgb(c));
    q_tag.push_back(tag);
  endtask

  task automatic wr(input int a, input logic [3:0] p);
    @(negedge clock);
    wr_en    = 1'b1;
    wr_addr  = 6'(a);
    wr_piece = p;
    @(negedge clock);
    wr_en    = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q_due.size() > 0; i++) @(negedge clock);
    total++;
    assert (q_due.size() == 0) else begin
      bad++;
      $error("FAIL drain: observed %0d pending expected 0", q_due.size());
      q_due.delete();
      q_exp.delete();
      q_tag.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 reset_n = 1'b0;
    #1 check("reset_out", {R, G, B}, 30'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Square colours and half-open edges
    px(250, 250, C_LIGHT, "sq00");
    px(300, 250, C_DARK,  "sq01_edge");
    px(299, 250, C_LIGHT, "sq00_edge");
    px(499, 250, C_LIGHT, "sq02_last");
    px(500, 250, C_OFF,   "right_out");
    px(199, 250, C_OFF,   "left_out");
    px(250, 199, C_OFF,   "top_out");
    px(250, 499, C_LIGHT, "sq20_last");
    px(250, 500, C_OFF,   "bot_out");
    px(250, 350, C_DARK,  "sq10");

    // Sprites
    wr(4, 4'b0101);
    px(355, 355, C_WPC,   "wq_body");
    px(301, 301, C_LIGHT, "wq_blank");
    wr(4, 4'b1101);
    px(355, 355, C_BPC,   "bq_body");
    px(301, 301, C_LIGHT, "bq_blank");
    wr(8, 4'b0110);
    px(455, 455, C_WPC,   "wk_body");
    px(455, 401, C_WPC,   "wk_top");

    // Write on the same edge S2 reads the square
    px(355, 355, C_WPC, "fwd_write");
    @(negedge clock);
    wr_en = 1'b1; wr_addr = 6'd4; wr_piece = 4'b0101;
    @(negedge clock);
    wr_en = 1'b0;
    drain();

    // Cursor border
    cursor = 6'd0;
    px(201, 250, C_CUR,   "cur_left");
    px(203, 250, C_CUR,   "cur_in3");
    px(204, 250, C_LIGHT, "cur_in4");
    px(250, 203, C_CUR,   "cur_top");
    px(250, 295, C_LIGHT, "cur_bot_in");
    px(250, 296, C_CUR,   "cur_bot");
    px(299, 250, C_CUR,   "cur_right");
    px(300, 250, C_DARK,  "cur_next_sq");
    drain();
    cursor = 6'd8;
    px(455, 401, C_CUR, "cur_over_sprite");
    px(455, 455, C_WPC, "cur_mid_sprite");
    drain();
    cursor = 6'd9;
    px(201, 250, C_LIGHT, "cur_oor");
    px(401, 401, C_LIGHT, "cur_oor_sq8");
    drain();

`ifdef CURSOR_BLINK_EN
    cursor = 6'd0;
    px(201, 250, C_CUR, "blink_on");
    drain();
    @(negedge clock);
    hcount = 11'd0;
    vcount = 10'd0;
    repeat (29) @(negedge clock);
    px(201, 250, C_LIGHT, "blink_off");
    drain();
`endif

    // Reset mid-line
    cursor = 6'd63;
    px(355, 355, C_WPC, "pre_rst");
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check("rst_async", {R, G, B}, 30'd0);
    repeat (2) @(negedge clock);
    check("rst_hold", {R, G, B}, 30'd0);
    reset_n = 1'b1;
    q_due.push_back(cyc + 3);
    q_exp.push_back(rgb(C_LIGHT));
    q_tag.push_back("rst_cleared");
    @(negedge clock);
    check("rst_fill1", {R, G, B}, 30'd0);
    @(negedge clock);
    check("rst_fill2", {R, G, B}, 30'd0);
    px(455, 455, C_LIGHT, "rst_cleared8");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
